// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns UART byte frames into device commands and replies with status, data.
// Frame is code, addr; with UART_CMD_CHECKSUM_EN defined a third byte (code ^ addr) follows.
// Reply is always two bytes: status (00 ok, FF bad command, EE no response, FC bad checksum)
// followed by data.
module uart_cmd_parser #(
  parameter int unsigned CLKS_PER_BIT       = 5208,
  parameter int unsigned FRAME_TIMEOUT_BITS = 100,
  parameter int unsigned RSP_TIMEOUT_CLKS   = 1000000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd_Code,
  output logic [7:0] o_Cmd_Addr,
  input  logic       i_Rsp_Valid,
  input  logic [7:0] i_Rsp_Data,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  output logic       o_Overrun
);

  localparam int unsigned FrameTimeoutClks = CLKS_PER_BIT * FRAME_TIMEOUT_BITS;
  localparam int unsigned FrameCntW        = $clog2(FrameTimeoutClks + 1);
  localparam int unsigned RspCntW          = $clog2(RSP_TIMEOUT_CLKS + 1);
  localparam logic [FrameCntW-1:0] FrameCntLast = FrameCntW'(FrameTimeoutClks - 1);
  localparam logic [RspCntW-1:0]   RspCntLast   = RspCntW'(RSP_TIMEOUT_CLKS - 1);

  localparam logic [7:0] StatusOk      = 8'h00;
  localparam logic [7:0] StatusBadCmd  = 8'hFF;
  localparam logic [7:0] StatusTimeout = 8'hEE;
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [7:0] StatusBadChk  = 8'hFC;
`endif

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
`ifdef UART_CMD_CHECKSUM_EN
    StGetChk,
`endif
    StIssue,
    StWaitRsp,
    StTxStat,
    StWaitTx0,
    StTxData,
    StWaitTx1
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           code_q, code_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           status_q, status_d;
  logic [7:0]           data_q, data_d;
  logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [RspCntW-1:0]   rsp_cnt_q, rsp_cnt_d;

  function automatic logic cmd_ok(input logic [7:0] code, input logic [7:0] addr);
    return (code >= 8'h01) && (code <= 8'h07) && (addr <= 8'h1F);
  endfunction

  // Next-state, latches and overrun detect; counters default to zero so they clear on exit.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    addr_d      = addr_q;
    status_d    = status_q;
    data_d      = data_q;
    frame_cnt_d = '0;
    rsp_cnt_d   = '0;
    o_Overrun   = i_Rx_DV;

    unique case (state_q)
      StIdle: begin
        o_Overrun = 1'b0;
        if (i_Rx_DV) begin
          code_d  = i_Rx_Byte;
          state_d = StGetAddr;
        end
      end

      StGetAddr: begin
        o_Overrun = 1'b0;
        if (i_Rx_DV) begin
          addr_d = i_Rx_Byte;
`ifdef UART_CMD_CHECKSUM_EN
          state_d = StGetChk;
`else
          if (cmd_ok(code_q, i_Rx_Byte)) begin
            state_d = StIssue;
          end else begin
            status_d = StatusBadCmd;
            data_d   = 8'h00;
            state_d  = StTxStat;
          end
`endif
        end else if (frame_cnt_q == FrameCntLast) begin
          state_d = StIdle;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end

`ifdef UART_CMD_CHECKSUM_EN
      StGetChk: begin
        o_Overrun = 1'b0;
        if (i_Rx_DV) begin
          if (i_Rx_Byte != (code_q ^ addr_q)) begin
            status_d = StatusBadChk;
            data_d   = 8'h00;
            state_d  = StTxStat;
          end else if (cmd_ok(code_q, addr_q)) begin
            state_d = StIssue;
          end else begin
            status_d = StatusBadCmd;
            data_d   = 8'h00;
            state_d  = StTxStat;
          end
        end else if (frame_cnt_q == FrameCntLast) begin
          state_d = StIdle;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
`endif

      StIssue: state_d = StWaitRsp;

      StWaitRsp: begin
        // A response landing on the timeout cycle still wins.
        if (i_Rsp_Valid) begin
          status_d = StatusOk;
          data_d   = i_Rsp_Data;
          state_d  = StTxStat;
        end else if (rsp_cnt_q == RspCntLast) begin
          status_d = StatusTimeout;
          data_d   = 8'h00;
          state_d  = StTxStat;
        end else begin
          rsp_cnt_d = rsp_cnt_q + 1'b1;
        end
      end

      StTxStat: state_d = StWaitTx0;

      StWaitTx0: if (i_Tx_Done) state_d = StTxData;

      StTxData: state_d = StWaitTx1;

      StWaitTx1: if (i_Tx_Done) state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      code_q      <= 8'h00;
      addr_q      <= 8'h00;
      status_q    <= 8'h00;
      data_q      <= 8'h00;
      frame_cnt_q <= '0;
      rsp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      addr_q      <= addr_d;
      status_q    <= status_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
    end
  end

  assign o_Cmd_Valid = (state_q == StIssue);
  assign o_Cmd_Code  = code_q;
  assign o_Cmd_Addr  = addr_q;
  assign o_Tx_DV     = (state_q == StTxStat) || (state_q == StTxData);
  // Byte select follows the state so it stays put until the matching i_Tx_Done.
  assign o_Tx_Byte   = ((state_q == StTxData) || (state_q == StWaitTx1)) ? data_q : status_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: device and transmitter models plus an expected-output scoreboard.
module tb_uart_cmd_parser;

  localparam int unsigned ClksPerBit = 4;
  localparam int unsigned FrameBits  = 10;
  localparam int unsigned RspClks    = 50;
  localparam int unsigned FrameClks  = ClksPerBit * FrameBits;
  localparam int          TxLat      = 3;
  localparam int          DevLat     = 3;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic       o_Cmd_Valid;
  logic [7:0] o_Cmd_Code;
  logic [7:0] o_Cmd_Addr;
  logic       i_Rsp_Valid;
  logic [7:0] i_Rsp_Data;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Done;
  logic       o_Overrun;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_cmd[$];
  logic [7:0]  exp_tx[$];
  logic        dev_respond = 1'b1;
  logic [7:0]  dev_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic        ovr_allowed = 1'b0;
  logic [15:0] mon_cmd;
  logic [7:0]  mon_tx;

  always #5 i_Clock = ~i_Clock;

  uart_cmd_parser #(
    .CLKS_PER_BIT      (ClksPerBit),
    .FRAME_TIMEOUT_BITS(FrameBits),
    .RSP_TIMEOUT_CLKS  (RspClks)
  ) dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Rx_DV    (i_Rx_DV),
    .i_Rx_Byte  (i_Rx_Byte),
    .o_Cmd_Valid(o_Cmd_Valid),
    .o_Cmd_Code (o_Cmd_Code),
    .o_Cmd_Addr (o_Cmd_Addr),
    .i_Rsp_Valid(i_Rsp_Valid),
    .i_Rsp_Data (i_Rsp_Data),
    .o_Tx_DV    (o_Tx_DV),
    .o_Tx_Byte  (o_Tx_Byte),
    .i_Tx_Done  (i_Tx_Done),
    .o_Overrun  (o_Overrun)
  );

  // Scoreboard: pop expected values as the DUT strobes its outputs.
  always @(negedge i_Clock) begin
    if (o_Cmd_Valid === 1'b1) begin
      checks++;
      if (exp_cmd.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got code=%02h addr=%02h, required no command",
                 o_Cmd_Code, o_Cmd_Addr);
      end else begin
        mon_cmd = exp_cmd.pop_front();
        if ({o_Cmd_Code, o_Cmd_Addr} !== mon_cmd) begin
          errors++;
          $display("FAIL cmd_value: got %02h/%02h, required %02h/%02h",
                   o_Cmd_Code, o_Cmd_Addr, mon_cmd[15:8], mon_cmd[7:0]);
        end
      end
    end
    if (o_Tx_DV === 1'b1) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got byte %02h, required no tx strobe", o_Tx_Byte);
      end else begin
        mon_tx = exp_tx.pop_front();
        if (o_Tx_Byte !== mon_tx) begin
          errors++;
          $display("FAIL tx_value: got %02h, required %02h", o_Tx_Byte, mon_tx);
        end
      end
    end
    if (o_Overrun === 1'b1) begin
      checks++;
      if (!ovr_allowed) begin
        errors++;
        $display("FAIL overrun_unexpected: got o_Overrun=1, required 0");
      end
    end
  end

  // Device model: answers each command after DevLat cycles when enabled.
  initial begin
    i_Rsp_Valid = 1'b0;
    i_Rsp_Data  = 8'h00;
    forever begin
      @(negedge i_Clock);
      if (o_Cmd_Valid === 1'b1 && dev_respond) begin
        repeat (DevLat) @(posedge i_Clock);
        #1;
        i_Rsp_Valid = 1'b1;
        i_Rsp_Data  = dev_data;
        @(posedge i_Clock);
        #1;
        i_Rsp_Valid = 1'b0;
      end
    end
  end

  // Transmitter model: busy for TxLat cycles per byte, then one-cycle done.
  initial begin
    logic [7:0] held;
    logic       aborted;
    i_Tx_Done = 1'b0;
    forever begin
      @(negedge i_Clock);
      if (o_Tx_DV === 1'b1) begin
        tx_busy = 1'b1;
        held    = o_Tx_Byte;
        aborted = 1'b0;
        for (int i = 0; i < TxLat; i++) begin
          @(negedge i_Clock);
          aborted = aborted | i_Reset;
          if (!aborted) begin
            checks++;
            if (o_Tx_DV !== 1'b0 || o_Tx_Byte !== held) begin
              errors++;
              $display("FAIL tx_busy_hold: got dv=%b byte=%02h, required dv=0 byte=%02h",
                       o_Tx_DV, o_Tx_Byte, held);
            end
          end
        end
        @(posedge i_Clock);
        #1;
        i_Tx_Done = 1'b1;
        @(posedge i_Clock);
        #1;
        i_Tx_Done = 1'b0;
        tx_busy   = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_Clock);
    #1;
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge i_Clock);
    #1;
    i_Rx_DV   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic [7:0] addr);
    send_byte(code);
    send_byte(addr);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(code ^ addr);
`endif
  endtask

  task automatic pulse_reset();
    @(posedge i_Clock);
    #1 i_Reset = 1'b1;
    @(posedge i_Clock);
    #1 i_Reset = 1'b0;
  endtask

  // Wait for all expected tx bytes; on expiry report leftovers, flush and reset.
  task automatic drain(output bit ok, output int cmd_left, output int tx_left);
    int n = 0;
    while ((exp_tx.size() != 0 || tx_busy) && n < 2000) begin
      @(posedge i_Clock);
      n++;
    end
    repeat (3) @(posedge i_Clock);
    #1;
    ok       = (n < 2000);
    cmd_left = exp_cmd.size();
    tx_left  = exp_tx.size();
    if (!ok || cmd_left != 0) begin
      exp_cmd.delete();
      exp_tx.delete();
      pulse_reset();
      repeat (20) @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_Clock);
    @(negedge i_Clock);
    checks += 6;
    if (o_Cmd_Valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b, required 0", o_Cmd_Valid); end
    if (o_Tx_DV !== 1'b0) begin errors++; $display("FAIL rst_tx_dv: got %b, required 0", o_Tx_DV); end
    if (o_Overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b, required 0", o_Overrun); end
    if (o_Cmd_Code !== 8'h00) begin errors++; $display("FAIL rst_code: got %02h, required 00", o_Cmd_Code); end
    if (o_Cmd_Addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %02h, required 00", o_Cmd_Addr); end
    if (o_Tx_Byte !== 8'h00) begin errors++; $display("FAIL rst_tx_byte: got %02h, required 00", o_Tx_Byte); end
    @(posedge i_Clock);
    #1 i_Reset = 1'b0;
  endtask

  task automatic test_valid_cmd();
    bit ok; int cl, tl;
    dev_data = 8'h3A;
    exp_cmd.push_back({8'h02, 8'h05});
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h3A);
    send_frame(8'h02, 8'h05);
    @(negedge i_Clock);
    checks++;
    if (o_Cmd_Valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_latency: got o_Cmd_Valid=%b one cycle after last byte, required 1", o_Cmd_Valid);
    end
    drain(ok, cl, tl);
    checks++;
    if (!ok || cl != 0 || tl != 0) begin
      errors++;
      $display("FAIL valid_done: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", ok, cl, tl);
    end
  endtask

  task automatic test_invalid_cmd();
    logic [7:0] codes[7];
    logic [7:0] addrs[7];
    logic       good[7];
    bit ok; int cl, tl;
    codes = '{8'h09, 8'h00, 8'h08, 8'h01, 8'hFF, 8'h07, 8'h01};
    addrs = '{8'h05, 8'h05, 8'h00, 8'h20, 8'hFF, 8'h1F, 8'h00};
    good  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      dev_data = 8'h50 + 8'(i);
      if (good[i]) begin
        exp_cmd.push_back({codes[i], addrs[i]});
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h50 + 8'(i));
      end else begin
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'h00);
      end
      send_frame(codes[i], addrs[i]);
      drain(ok, cl, tl);
      checks++;
      if (!ok || cl != 0 || tl != 0) begin
        errors++;
        $display("FAIL range_%02h_%02h: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0",
                 codes[i], addrs[i], ok, cl, tl);
      end
    end
  endtask

  task automatic test_frame_timeout();
    bit ok; int cl, tl;
    dev_data = 8'h5C;
    send_byte(8'h01);
    repeat (FrameClks + 5) @(posedge i_Clock);
    exp_cmd.push_back({8'h03, 8'h10});
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h5C);
    send_frame(8'h03, 8'h10);
    drain(ok, cl, tl);
    checks++;
    if (!ok || cl != 0 || tl != 0) begin
      errors++;
      $display("FAIL frame_timeout: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", ok, cl, tl);
    end
    // A byte arriving shortly before the timeout still completes the frame.
    dev_data = 8'h61;
    exp_cmd.push_back({8'h04, 8'h06});
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h61);
    send_byte(8'h04);
    repeat (FrameClks - 4) @(posedge i_Clock);
    send_byte(8'h06);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h04 ^ 8'h06);
`endif
    drain(ok, cl, tl);
    checks++;
    if (!ok || cl != 0 || tl != 0) begin
      errors++;
      $display("FAIL frame_in_window: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", ok, cl, tl);
    end
  endtask

  task automatic test_rsp_timeout();
    bit ok; int cl, tl;
    dev_respond = 1'b0;
    exp_cmd.push_back({8'h01, 8'h02});
    exp_tx.push_back(8'hEE);
    exp_tx.push_back(8'h00);
    send_frame(8'h01, 8'h02);
    repeat (10) @(posedge i_Clock);
    // Byte during WAIT_RSP must be dropped with an overrun pulse.
    #1;
    ovr_allowed = 1'b1;
    i_Rx_DV     = 1'b1;
    i_Rx_Byte   = 8'h07;
    @(negedge i_Clock);
    checks++;
    if (o_Overrun !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait_overrun: got %b, required 1", o_Overrun);
    end
    @(posedge i_Clock);
    #1;
    i_Rx_DV     = 1'b0;
    ovr_allowed = 1'b0;
    repeat (RspClks / 2) @(posedge i_Clock);
    #1;
    checks++;
    if ({o_Cmd_Code, o_Cmd_Addr} !== {8'h01, 8'h02}) begin
      errors++;
      $display("FAIL rsp_wait_hold: got %02h/%02h, required 01/02", o_Cmd_Code, o_Cmd_Addr);
    end
    drain(ok, cl, tl);
    dev_respond = 1'b1;
    checks++;
    if (!ok || cl != 0 || tl != 0) begin
      errors++;
      $display("FAIL rsp_timeout: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", ok, cl, tl);
    end
  endtask

  task automatic test_overrun();
    bit ok; int cl, tl;
    int n = 0;
    dev_data = 8'hA5;
    exp_cmd.push_back({8'h04, 8'h11});
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hA5);
    send_frame(8'h04, 8'h11);
    while (o_Tx_DV !== 1'b1 && n < 500) begin
      @(negedge i_Clock);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL overrun_wait: got no status strobe in 500 cycles, required one");
    end
    @(posedge i_Clock);
    #1;
    ovr_allowed = 1'b1;
    i_Rx_DV     = 1'b1;
    i_Rx_Byte   = 8'h01;
    @(negedge i_Clock);
    checks++;
    if (o_Overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got %b, required 1", o_Overrun);
    end
    @(posedge i_Clock);
    #1;
    i_Rx_DV     = 1'b0;
    ovr_allowed = 1'b0;
    drain(ok, cl, tl);
    checks++;
    if (!ok || cl != 0 || tl != 0) begin
      errors++;
      $display("FAIL overrun_seq: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", ok, cl, tl);
    end
  endtask

  task automatic test_reset_abort();
    bit ok; int cl, tl;
    int n = 0;
    // Reset mid-frame: the partial code must be forgotten.
    send_byte(8'h02);
    pulse_reset();
    @(negedge i_Clock);
    checks++;
    if (o_Cmd_Code !== 8'h00) begin
      errors++;
      $display("FAIL midframe_rst_code: got %02h, required 00", o_Cmd_Code);
    end
    dev_data = 8'h77;
    exp_cmd.push_back({8'h05, 8'h01});
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h77);
    send_frame(8'h05, 8'h01);
    drain(ok, cl, tl);
    checks++;
    if (!ok || cl != 0 || tl != 0) begin
      errors++;
      $display("FAIL midframe_rst: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", ok, cl, tl);
    end
    // Reset mid-transmit: status goes out, the data byte must never be strobed.
    dev_data = 8'h66;
    exp_cmd.push_back({8'h02, 8'h03});
    exp_tx.push_back(8'h00);
    send_frame(8'h02, 8'h03);
    while (o_Tx_DV !== 1'b1 && n < 500) begin
      @(negedge i_Clock);
      n++;
    end
    pulse_reset();
    n = 0;
    while (tx_busy && n < 500) begin
      @(posedge i_Clock);
      n++;
    end
    repeat (10) @(posedge i_Clock);
    #1;
    checks++;
    if (exp_tx.size() != 0 || exp_cmd.size() != 0 || n >= 500) begin
      errors++;
      $display("FAIL midtx_rst: got tx_left=%0d cmd_left=%0d wait=%0d, required 0/0/<500",
               exp_tx.size(), exp_cmd.size(), n);
      exp_tx.delete();
      exp_cmd.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes[3];
    logic [7:0] addrs[3];
    logic [7:0] datas[3];
    bit ok; int cl, tl;
    codes = '{8'h06, 8'h07, 8'h01};
    addrs = '{8'h1E, 8'h20, 8'h01};
    datas = '{8'h12, 8'h00, 8'hFE};
    for (int i = 0; i < 3; i++) begin
      dev_data = datas[i];
      if (i != 1) begin
        exp_cmd.push_back({codes[i], addrs[i]});
        exp_tx.push_back(8'h00);
      end else begin
        exp_tx.push_back(8'hFF);
      end
      exp_tx.push_back(datas[i]);
      send_frame(codes[i], addrs[i]);
      drain(ok, cl, tl);
      checks++;
      if (!ok || cl != 0 || tl != 0) begin
        errors++;
        $display("FAIL b2b_%0d: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", i, ok, cl, tl);
      end
    end
  endtask

`ifdef UART_CMD_CHECKSUM_EN
  task automatic test_checksum();
    bit ok; int cl, tl;
    dev_data = 8'h3A;
    exp_cmd.push_back({8'h02, 8'h05});
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h3A);
    send_byte(8'h02);
    send_byte(8'h05);
    send_byte(8'h07);
    drain(ok, cl, tl);
    checks++;
    if (!ok || cl != 0 || tl != 0) begin
      errors++;
      $display("FAIL chk_ok: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", ok, cl, tl);
    end
    exp_tx.push_back(8'hFC);
    exp_tx.push_back(8'h00);
    send_byte(8'h02);
    send_byte(8'h05);
    send_byte(8'h00);
    drain(ok, cl, tl);
    checks++;
    if (!ok || cl != 0 || tl != 0) begin
      errors++;
      $display("FAIL chk_bad: got drained=%0d cmd_left=%0d tx_left=%0d, required 1/0/0", ok, cl, tl);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_valid_cmd();
    test_invalid_cmd();
    test_frame_timeout();
    test_rsp_timeout();
    test_overrun();
    test_reset_abort();
    test_back_to_back();
`ifdef UART_CMD_CHECKSUM_EN
    test_checksum();
`endif
    repeat (5) @(posedge i_Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, baud divisor shared with the UART receiver and transmitter.
REQ-002 SHALL have parameter FRAME_TIMEOUT_BITS, default 100, inter-byte timeout in bit times (timeout = CLKS_PER_BIT*FRAME_TIMEOUT_BITS cycles).
REQ-003 SHALL have parameter RSP_TIMEOUT_CLKS, default 1000000, device-response timeout in cycles.
REQ-004 SHALL have port i_Clock  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port i_Reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port i_Rx_DV  input  1  one-cycle strobe from the UART receiver, byte valid.
REQ-007 SHALL have port i_Rx_Byte  input  8  received byte, sampled when i_Rx_DV=1.
REQ-008 SHALL have port o_Cmd_Valid  output  1  one-cycle command strobe to the device.
REQ-009 SHALL have port o_Cmd_Code  output  8  command code, stable from o_Cmd_Valid until the response completes.
REQ-010 SHALL have port o_Cmd_Addr  output  8  command address, same stability rule as o_Cmd_Code.
REQ-011 SHALL have port i_Rsp_Valid  input  1  one-cycle device response strobe.
REQ-012 SHALL have port i_Rsp_Data  input  8  response data, sampled when i_Rsp_Valid=1.
REQ-013 SHALL have port o_Tx_DV  output  1  one-cycle strobe to the UART transmitter.
REQ-014 SHALL have port o_Tx_Byte  output  8  byte to send, held stable from o_Tx_DV until i_Tx_Done.
REQ-015 SHALL have port i_Tx_Done  input  1  one-cycle strobe from the transmitter, byte sent.
REQ-016 SHALL have port o_Overrun  output  1  one-cycle pulse when an Rx byte is dropped.

Function
REQ-017 SHALL implement states IDLE, GET_ADDR, GET_CHK (macro only), ISSUE, WAIT_RSP, TX_STAT, WAIT_TX0, TX_DATA, WAIT_TX1.
REQ-018 SHALL, in IDLE on i_Rx_DV, latch i_Rx_Byte as the command code and go to GET_ADDR.
REQ-019 SHALL, in GET_ADDR on i_Rx_DV, latch the address and go to GET_CHK if the checksum macro is defined, else ISSUE.
REQ-020 SHALL, in GET_ADDR/GET_CHK, return to IDLE and discard the partial frame if no byte arrives within the frame timeout; the counter restarts on each accepted byte.
REQ-021 SHALL treat code 0x01..0x07 with address 0x00..0x1F as valid; otherwise skip the device and transmit status 0xFF, data 0x00.
REQ-022 SHALL, in ISSUE, pulse o_Cmd_Valid for exactly one cycle, then go to WAIT_RSP; latency from the last frame byte strobe to o_Cmd_Valid is 1 cycle.
REQ-023 SHALL ignore i_Rsp_Valid except in WAIT_RSP; in WAIT_RSP, latch i_Rsp_Data with status 0x00.
REQ-024 SHALL, if RSP_TIMEOUT_CLKS cycles elapse in WAIT_RSP, use status 0xEE with data 0x00; simultaneous i_Rsp_Valid and timeout gives priority to i_Rsp_Valid.
REQ-025 SHALL send status then data: pulse o_Tx_DV in TX_STAT, wait for i_Tx_Done, pulse o_Tx_DV in TX_DATA the cycle after, wait for i_Tx_Done, then return to IDLE.
REQ-026 SHALL drop any i_Rx_DV arriving in ISSUE through WAIT_TX1 and pulse o_Overrun in the same cycle.
REQ-027 SHALL never assert o_Tx_DV while a previous byte is awaiting i_Tx_Done.
REQ-028 SHALL size each timeout counter to its terminal count with no wrap-around; the counter saturates and is cleared on state exit.

Reset
REQ-029 SHALL, while i_Reset=1 at a clock edge, enter IDLE and clear all counters and latches.
REQ-030 SHALL reset o_Cmd_Valid, o_Tx_DV and o_Overrun to 0, and o_Cmd_Code, o_Cmd_Addr and o_Tx_Byte to 0x00.
REQ-031 SHALL, on reset mid-frame or mid-transmit, abort without further strobes; the in-flight byte is owned by the transmitter.

Configuration
REQ-032 SHALL support the macro UART_CMD_CHECKSUM_EN. When defined, a frame is 3 bytes and the third byte must equal code XOR address; on mismatch, skip the device and transmit status 0xFC, data 0x00. When undefined, a frame is 2 bytes, GET_CHK is absent, and status 0xFC is never produced.

Verification
REQ-033 SHALL cover: Rx 0x02,0x05 then device i_Rsp_Data=0x3A -> o_Cmd_Valid with code 0x02/addr 0x05, then Tx 0x00,0x3A.
REQ-034 SHALL cover: Rx 0x09,0x05 -> no o_Cmd_Valid, Tx 0xFF,0x00.
REQ-035 SHALL cover: Rx 0x01 only, wait past the frame timeout, then Rx 0x03,0x10 -> command code 0x03/addr 0x10.
REQ-036 SHALL cover: valid frame with no device response for RSP_TIMEOUT_CLKS -> Tx 0xEE,0x00.
REQ-037 SHALL cover: Rx byte during WAIT_TX0 -> o_Overrun pulse, byte discarded, Tx sequence unchanged.
REQ-038 SHALL cover: with UART_CMD_CHECKSUM_EN defined, Rx 0x02,0x05,0x07 -> OK path; Rx 0x02,0x05,0x00 -> Tx 0xFC,0x00.
